// File: rtl/matrix_slot_store.sv
// Slot allocator and element RAM for incoming matrices: scan/grant replacement, windowed writes,
// registered read port. Define MSTORE_RD_BYPASS_EN for write-first read behaviour on collisions.
module matrix_slot_store #(
  parameter int unsigned NUM_SLOTS   = 10,
  parameter int unsigned MAX_PER_DIM = 2,
  parameter int unsigned MAT_WORDS   = 25,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req,
  input  logic [2:0]           alloc_m,
  input  logic [2:0]           alloc_n,
  output logic                 addr_ready,
  output logic [ADDR_W-1:0]    base_addr,
  output logic [3:0]           alloc_slot,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 commit,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic [NUM_SLOTS-1:0] valid_mask,
  output logic                 drop_flag,
  output logic                 busy
);

  localparam int unsigned Depth   = NUM_SLOTS * MAT_WORDS;
  localparam int unsigned AddrW1  = ADDR_W + 1;
  localparam logic [ADDR_W:0] DepthW = AddrW1'(Depth);
  localparam logic [ADDR_W:0] WinW   = AddrW1'(MAT_WORDS);
  localparam logic [3:0] LastSlot    = 4'(NUM_SLOTS - 1);
  localparam logic [3:0] ClassCap    = 4'(MAX_PER_DIM);

  typedef enum logic [1:0] {StIdle, StScan, StGrant, StFill} state_e;
  state_e state_q, state_d;

  logic [2:0]           req_m_q, req_m_d, req_n_q, req_n_d;
  logic [3:0]           scan_idx_q, scan_idx_d;
  logic [3:0]           cls_cnt_q, cls_cnt_d, cls_idx_q, cls_idx_d;
  logic [7:0]           cls_age_q, cls_age_d;
  logic                 free_found_q, free_found_d;
  logic [3:0]           free_idx_q, free_idx_d;
  logic                 glob_found_q, glob_found_d;
  logic [3:0]           glob_idx_q, glob_idx_d;
  logic [7:0]           glob_age_q, glob_age_d;
  logic [3:0]           slot_q, slot_d, choice;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic                 addr_ready_q, addr_ready_d;
  logic                 drop_q, drop_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [7:0]           age_q [NUM_SLOTS];
  logic [7:0]           age_d [NUM_SLOTS];
  logic [2:0]           slot_m_q [NUM_SLOTS];
  logic [2:0]           slot_m_d [NUM_SLOTS];
  logic [2:0]           slot_n_q [NUM_SLOTS];
  logic [2:0]           slot_n_d [NUM_SLOTS];
  logic [DATA_W-1:0]    mem [Depth];
  logic [DATA_W-1:0]    rd_data_q;
  logic                 wr_in_win, wr_accept, scan_hit;
  logic [ADDR_W:0]      wr_ext, base_ext;
  logic                 unused_wr_bits;

  function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
    return (m >= 3'd1) && (m <= 3'd5) && (n >= 3'd1) && (n <= 3'd5);
  endfunction

  assign unused_wr_bits = ^wr_data[31:DATA_W];
  assign wr_ext    = {1'b0, wr_addr};
  assign base_ext  = {1'b0, base_q};
  assign wr_in_win = (wr_ext >= base_ext) && (wr_ext < base_ext + WinW);
  assign wr_accept = wr_en && (state_q == StFill) && wr_in_win && !rst_n;
  assign scan_hit  = valid_q[scan_idx_q] && (slot_m_q[scan_idx_q] == req_m_q) &&
                     (slot_n_q[scan_idx_q] == req_n_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (alloc_req && dims_ok(alloc_m, alloc_n)) state_d = StScan;
      StScan:  if (scan_idx_q == LastSlot) state_d = StGrant;
      StGrant: state_d = StFill;
      StFill: begin
        if (abort || commit)  state_d = StIdle;
        else if (alloc_req)   state_d = dims_ok(alloc_m, alloc_n) ? StScan : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: scan accumulators, grant choice, commit bookkeeping
  always_comb begin
    req_m_d      = req_m_q;
    req_n_d      = req_n_q;
    scan_idx_d   = scan_idx_q;
    cls_cnt_d    = cls_cnt_q;
    cls_idx_d    = cls_idx_q;
    cls_age_d    = cls_age_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    glob_found_d = glob_found_q;
    glob_idx_d   = glob_idx_q;
    glob_age_d   = glob_age_q;
    slot_d       = slot_q;
    base_d       = base_q;
    addr_ready_d = 1'b0;
    drop_d       = drop_q | (wr_en & ~wr_accept);
    valid_d      = valid_q;
    age_d        = age_q;
    slot_m_d     = slot_m_q;
    slot_n_d     = slot_n_q;
    choice       = '0;

    if ((state_d == StScan) && (state_q != StScan)) begin
      req_m_d      = alloc_m;
      req_n_d      = alloc_n;
      scan_idx_d   = '0;
      cls_cnt_d    = '0;
      free_found_d = 1'b0;
      glob_found_d = 1'b0;
    end

    unique case (state_q)
      StScan: begin
        // Strict '>' while walking upward keeps age ties on the lower index
        if (scan_hit) begin
          cls_cnt_d = cls_cnt_q + 4'd1;
          if ((cls_cnt_q == '0) || (age_q[scan_idx_q] > cls_age_q)) begin
            cls_idx_d = scan_idx_q;
            cls_age_d = age_q[scan_idx_q];
          end
        end
        if (!valid_q[scan_idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        if (valid_q[scan_idx_q] && (!glob_found_q || (age_q[scan_idx_q] > glob_age_q))) begin
          glob_found_d = 1'b1;
          glob_idx_d   = scan_idx_q;
          glob_age_d   = age_q[scan_idx_q];
        end
        scan_idx_d = scan_idx_q + 4'd1;
      end
      StGrant: begin
        if (cls_cnt_q >= ClassCap) choice = cls_idx_q;
        else if (free_found_q)     choice = free_idx_q;
        else                       choice = glob_idx_q;
        slot_d          = choice;
        base_d          = ADDR_W'(32'(choice) * MAT_WORDS);
        valid_d[choice] = 1'b0;
        addr_ready_d    = 1'b1;
        drop_d          = wr_en;
      end
      StFill: begin
        // A fresh alloc_req while filling commits the current slot implicitly
        if (!abort && (commit || alloc_req)) begin
          for (int j = 0; j < NUM_SLOTS; j++) begin
            if (4'(j) == slot_q) begin
              valid_d[j]  = 1'b1;
              age_d[j]    = '0;
              slot_m_d[j] = req_m_q;
              slot_n_d[j] = req_n_q;
            end else if (valid_q[j] && (age_q[j] != 8'hFF)) begin
              age_d[j] = age_q[j] + 8'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      req_m_q      <= '0;
      req_n_q      <= '0;
      scan_idx_q   <= '0;
      cls_cnt_q    <= '0;
      cls_idx_q    <= '0;
      cls_age_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      glob_found_q <= 1'b0;
      glob_idx_q   <= '0;
      glob_age_q   <= '0;
      slot_q       <= '0;
      base_q       <= '0;
      addr_ready_q <= 1'b0;
      drop_q       <= 1'b0;
      valid_q      <= '0;
      for (int j = 0; j < NUM_SLOTS; j++) begin
        age_q[j]    <= '0;
        slot_m_q[j] <= '0;
        slot_n_q[j] <= '0;
      end
    end else begin
      req_m_q      <= req_m_d;
      req_n_q      <= req_n_d;
      scan_idx_q   <= scan_idx_d;
      cls_cnt_q    <= cls_cnt_d;
      cls_idx_q    <= cls_idx_d;
      cls_age_q    <= cls_age_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      glob_found_q <= glob_found_d;
      glob_idx_q   <= glob_idx_d;
      glob_age_q   <= glob_age_d;
      slot_q       <= slot_d;
      base_q       <= base_d;
      addr_ready_q <= addr_ready_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      age_q        <= age_d;
      slot_m_q     <= slot_m_d;
      slot_n_q     <= slot_n_d;
    end
  end

  // Element RAM, contents not reset
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= wr_data[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_data_q <= '0;
    end else if ({1'b0, rd_addr} >= DepthW) begin
      rd_data_q <= '0;
`ifdef MSTORE_RD_BYPASS_EN
    end else if (wr_accept && (wr_addr == rd_addr)) begin
      rd_data_q <= wr_data[DATA_W-1:0];
`endif
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Outputs
  always_comb begin
    addr_ready = addr_ready_q;
    base_addr  = base_q;
    alloc_slot = slot_q;
    rd_data    = rd_data_q;
    valid_mask = valid_q;
    drop_flag  = drop_q;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_matrix_slot_store.sv
// Directed bench for matrix_slot_store: allocation policy, write window, commit/abort, read port.
module tb_matrix_slot_store;

  logic        clk, rst_n, alloc_req;
  logic [2:0]  alloc_m, alloc_n;
  logic        addr_ready;
  logic [7:0]  base_addr;
  logic [3:0]  alloc_slot;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit, abort;
  logic [7:0]  rd_addr;
  logic [3:0]  rd_data;
  logic [9:0]  valid_mask;
  logic        drop_flag, busy;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  matrix_slot_store dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_req  (alloc_req),
    .alloc_m    (alloc_m),
    .alloc_n    (alloc_n),
    .addr_ready (addr_ready),
    .base_addr  (base_addr),
    .alloc_slot (alloc_slot),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .valid_mask (valid_mask),
    .drop_flag  (drop_flag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic do_alloc(input logic [2:0] m, input logic [2:0] n, output int l);
    alloc_req = 1'b1;
    alloc_m   = m;
    alloc_n   = n;
    tick();
    alloc_req = 1'b0;
    l = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      l++;
      if (addr_ready) break;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; alloc_req = 1'b0; alloc_m = '0; alloc_n = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; abort = 1'b0; rd_addr = '0;

    // Reset values
    do_reset();
    check("rst_addr_ready", 32'(addr_ready), 32'd0);
    check("rst_base_addr",  32'(base_addr),  32'd0);
    check("rst_alloc_slot", 32'(alloc_slot), 32'd0);
    check("rst_rd_data",    32'(rd_data),    32'd0);
    check("rst_valid_mask", 32'(valid_mask), 32'd0);
    check("rst_drop_flag",  32'(drop_flag),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);

    // Illegal dims ignored
    alloc_req = 1'b1; alloc_m = 3'd6; alloc_n = 3'd2;
    tick();
    alloc_req = 1'b0;
    tick();
    check("illegal_dims_idle", 32'(busy), 32'd0);

    // 1: alloc 2x3, six writes, commit
    do_alloc(3'd2, 3'd3, lat);
    check("t1_latency", 32'(lat), 32'd11);
    check("t1_base", 32'(base_addr), 32'd0);
    check("t1_slot", 32'(alloc_slot), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) wr(8'(i), 32'hABCD_0000 | 32'(i + 1));
    do_commit();
    check("t1_valid", 32'(valid_mask), 32'h001);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_nodrop", 32'(drop_flag), 32'd0);
    rd_addr = 8'd2;
    tick();
    check("t1_read2", 32'(rd_data), 32'd3);
    rd_addr = 8'd250;
    tick();
    check("t1_read_oob", 32'(rd_data), 32'd0);

    // 2: three 2x2 matrices, class cap reuses oldest in class
    do_reset();
    do_alloc(3'd2, 3'd2, lat);
    check("t2_base_a", 32'(base_addr), 32'd0);
    do_commit();
    do_alloc(3'd2, 3'd2, lat);
    check("t2_base_b", 32'(base_addr), 32'd25);
    check("t2_slot_b", 32'(alloc_slot), 32'd1);
    do_commit();
    do_alloc(3'd2, 3'd2, lat);
    check("t2_base_c", 32'(base_addr), 32'd0);
    check("t2_slot_c", 32'(alloc_slot), 32'd0);
    check("t2_valid_fill", 32'(valid_mask), 32'h002);
    do_abort();
    check("t2_valid_abort", 32'(valid_mask), 32'h002);

    // 3: fill all slots, new class evicts globally oldest
    do_reset();
    for (int k = 0; k < 10; k++) begin
      do_alloc(3'(k / 5 + 1), 3'(k % 5 + 1), lat);
      do_commit();
    end
    check("t3_last_base", 32'(base_addr), 32'd225);
    check("t3_last_slot", 32'(alloc_slot), 32'd9);
    check("t3_full", 32'(valid_mask), 32'h3FF);
    do_alloc(3'd4, 3'd4, lat);
    check("t3_latency", 32'(lat), 32'd11);
    check("t3_base", 32'(base_addr), 32'd0);
    check("t3_valid_fill", 32'(valid_mask), 32'h3FE);
    do_commit();
    check("t3_valid_commit", 32'(valid_mask), 32'h3FF);

    // 4: out-of-window write, abort, drop flag behaviour
    do_reset();
    do_alloc(3'd1, 3'd1, lat);
    do_commit();
    do_alloc(3'd1, 3'd2, lat);
    check("t4_base", 32'(base_addr), 32'd25);
    check("t4_drop_initial", 32'(drop_flag), 32'd0);
    wr(8'd50, 32'd7);
    check("t4_drop_set", 32'(drop_flag), 32'd1);
    wr(8'd30, 32'd6);
    do_abort();
    check("t4_valid", 32'(valid_mask), 32'h001);
    check("t4_drop_sticky", 32'(drop_flag), 32'd1);
    do_alloc(3'd1, 3'd2, lat);
    check("t4_regrant_base", 32'(base_addr), 32'd25);
    check("t4_drop_cleared", 32'(drop_flag), 32'd0);
    do_abort();
    wr(8'd30, 32'd9);
    check("t4_idle_write_drop", 32'(drop_flag), 32'd1);
    rd_addr = 8'd30;
    tick();
    check("t4_read30", 32'(rd_data), 32'd6);

    // 5: gen mode implicit commit
    do_reset();
    do_alloc(3'd3, 3'd3, lat);
    for (int i = 0; i < 25; i++) wr(8'(i), 32'(i % 16));
    do_alloc(3'd3, 3'd3, lat);
    check("t5_latency", 32'(lat), 32'd11);
    check("t5_base", 32'(base_addr), 32'd25);
    check("t5_slot", 32'(alloc_slot), 32'd1);
    check("t5_valid_fill", 32'(valid_mask), 32'h001);
    do_commit();
    check("t5_valid_commit", 32'(valid_mask), 32'h003);
    rd_addr = 8'd24;
    tick();
    check("t5_read24", 32'(rd_data), 32'd8);

    // 6: read/write collision, then mid-fill reset
    do_reset();
    do_alloc(3'd1, 3'd1, lat);
    wr(8'd7, 32'd3);
    rd_addr = 8'd7;
    wr(8'd7, 32'h19);
`ifdef MSTORE_RD_BYPASS_EN
    check("t6_collision", 32'(rd_data), 32'd9);
`else
    check("t6_collision", 32'(rd_data), 32'd3);
`endif
    tick();
    check("t6_after", 32'(rd_data), 32'd9);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(valid_mask), 32'd0);
    check("t6_rst_rd", 32'(rd_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
